// File: rtl/led_matrix_scanner.sv
// Multiplexed LED matrix scanner: one row at a time with a dark gap before each row, frame snapshot per scan.
// Define LED_PWM_EN to add the 4-bit brightness input that trims column on-time within each row dwell.
module led_matrix_scanner #(
  parameter int ROWS         = 5,
  parameter int COLS         = 8,
  parameter int DWELL_CYCLES = 64,
  parameter int BLANK_CYCLES = 4,
  parameter int ROW_ACT_LOW  = 0,
  parameter int COL_ACT_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    scan_en,
  input  logic [ROWS*COLS-1:0]    frame_data,
`ifdef LED_PWM_EN
  input  logic [3:0]              brightness,
`endif
  output logic [ROWS-1:0]         led_row,
  output logic [COLS-1:0]         led_col,
  output logic [$clog2(ROWS)-1:0] row_idx,
  output logic                    frame_start
);

  localparam int RW    = $clog2(ROWS);
  localparam int CMAX  = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W = $clog2(CMAX + 1);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [RW-1:0]    ROW_LAST   = RW'(ROWS - 1);
  localparam logic [ROWS-1:0]  ROW_OFF    = {ROWS{(ROW_ACT_LOW != 0)}};
  localparam logic [COLS-1:0]  COL_OFF    = {COLS{(COL_ACT_LOW != 0)}};

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [RW-1:0]          r_row, w_row_nxt;
  logic [ROWS*COLS-1:0]   r_snap, w_snap_src;
  logic [COLS-1:0]        r_col_pat, w_col_pat_nxt, w_row_pat;
  logic                   w_capture;
  logic                   w_col_on;
  logic [ROWS-1:0]        w_lit_row, w_row_pins, r_led_row;
  logic [COLS-1:0]        w_lit_col, w_col_pins, r_led_col;
  logic                   r_fs;

  // Capture happens on the first BLANK cycle of row 0; the bypass lets a 1-cycle blank load the fresh frame.
  always_comb begin
    w_capture  = scan_en && (r_state == ST_BLANK) && (r_row == '0) && (r_cnt == '0);
    w_snap_src = w_capture ? frame_data : r_snap;
    w_row_pat  = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (r_row == RW'(r)) w_row_pat = w_snap_src[r*COLS +: COLS];
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_row_nxt     = r_row;
    w_col_pat_nxt = r_col_pat;
    if (!scan_en) begin
      w_state_nxt = ST_BLANK;
      w_cnt_nxt   = '0;
      w_row_nxt   = '0;
    end else begin
      case (r_state)
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_col_pat_nxt = w_row_pat;
            w_state_nxt   = ST_DRIVE;
            w_cnt_nxt     = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (r_cnt == DWELL_LAST) begin
            w_row_nxt   = (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          w_row_nxt   = '0;
        end
      endcase
    end
  end

`ifdef LED_PWM_EN
  logic [3:0]       r_bright_q;
  logic [CNT_W-1:0] w_on_cycles;

  function automatic logic [CNT_W-1:0] pwm_on_cycles(input logic [3:0] b);
    int t;
    t = (DWELL_CYCLES * (int'(b) + 1)) >> 4;
    if (t < 1) t = 1;
    return CNT_W'(t);
  endfunction

  always_comb w_on_cycles = pwm_on_cycles(r_bright_q);
  assign w_col_on = (r_cnt < w_on_cycles);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bright_q <= 4'hF;
    end else if (w_capture) begin
      r_bright_q <= brightness;
    end
  end
`else
  assign w_col_on = 1'b1;
`endif

  // Pin image derived from the current state; registered below, so pins trail the state by one clock.
  always_comb begin
    w_lit_row = '0;
    w_lit_col = '0;
    if (scan_en && (r_state == ST_DRIVE)) begin
      for (int r = 0; r < ROWS; r++) begin
        w_lit_row[r] = (r_row == RW'(r));
      end
      if (w_col_on) w_lit_col = r_col_pat;
    end
    w_row_pins = w_lit_row ^ ROW_OFF;
    w_col_pins = w_lit_col ^ COL_OFF;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_BLANK;
      r_cnt     <= '0;
      r_row     <= '0;
      r_snap    <= '0;
      r_col_pat <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_row     <= w_row_nxt;
      r_col_pat <= w_col_pat_nxt;
      if (w_capture) r_snap <= frame_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_led_row <= ROW_OFF;
      r_led_col <= COL_OFF;
      r_fs      <= 1'b0;
    end else begin
      r_led_row <= w_row_pins;
      r_led_col <= w_col_pins;
      r_fs      <= w_capture;
    end
  end

  assign led_row     = r_led_row;
  assign led_col     = r_led_col;
  assign row_idx     = r_row;
  assign frame_start = r_fs;

endmodule
